// File: rtl/mult_div_controller.sv
// Multi-cycle HI/LO multiply/divide sequencer: shift-add multiply, restoring divide, MTHI/MTLO.
// Optional macro MULT_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module mult_div_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               last_iter;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        signed_op = ~op[0];
        a_mag     = magnitude(rs_val, signed_op);
        b_mag     = magnitude(rt_val, signed_op);
        trial     = acc_q[2*WIDTH-1:WIDTH-1];
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
        prod      = neg_res_q ? -acc_q : acc_q;
        last_iter = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CALC;
                    count_d   = CW'(WIDTH);
                    is_div_d  = op[1];
                    neg_res_d = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_rem_d = signed_op & rs_val[WIDTH-1];
                    opb_d     = b_mag;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                        opa_d = {{WIDTH{1'b0}}, b_mag};
                    end else begin
                        acc_d = '0;
                        opa_d = {{WIDTH{1'b0}}, a_mag};
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                count_d = count_q - CW'(1);
                if (is_div_q) begin
                    // Remainder lives in the upper half, dividend bits shift out of the lower half
                    // while quotient bits shift in behind them.
                    if (trial >= {1'b0, opa_q[WIDTH-1:0]})
                        acc_d = {trial[WIDTH-1:0] - opa_q[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    if (opb_q[0]) acc_d = acc_q + opa_q;
                    opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end
                last_iter = (count_q == CW'(1));
`ifdef MULT_EARLY_TERM_EN
                if (!is_div_q && opb_d == '0) last_iter = 1'b1;
`endif
                if (last_iter) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (is_div_q) begin
                    // A zero divisor leaves rem = |dividend|, so the sign fixup restores rs_val.
                    lo_d = (opa_q[WIDTH-1:0] == '0) ? '1 : apply_sign(quo, neg_res_q);
                    hi_d = apply_sign(rem, neg_rem_q);
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign stall = ((state_q == S_IDLE) & start) | (state_q == S_CALC) | (state_q == S_FIX);
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_mult_div_controller.sv
// Scoreboard bench for mult_div_controller: expected HI/LO and latency queued at issue, checked on done.
module tb_mult_div_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        stall, busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] exp_res_q[$];
    int          exp_lat_q[$];
    int          exp_iss_q[$];

    mult_div_controller #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin p = 64'(sa * sb); return p; end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                p = {32'(r), 32'(q)};
                return p;
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
        int n;
        logic [31:0] m;
        n = 32;
`ifdef MULT_EARLY_TERM_EN
        if (!o[1]) begin
            m = (o == 2'b00 && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        end
`else
        m = b;
`endif
        return n + 2;
    endfunction

    // Scoreboard: every done pulse pops one expected transaction.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            checks++;
            if (exp_res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
            end else begin
                logic [63:0] e;
                int l, iss;
                e = exp_res_q.pop_front();
                l = exp_lat_q.pop_front();
                iss = exp_iss_q.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL result: hi/lo=%h/%h required %h/%h", hi, lo, e[63:32], e[31:0]);
                end
                checks++;
                if (cyc - iss !== l) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d required %0d", cyc - iss, l);
                end
            end
        end
    end

    task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit push, input bit wr);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        hi_we = wr; lo_we = wr; wdata = 32'h0BAD0BAD;
        if (push) begin
            exp_res_q.push_back(model(o, a, b));
            exp_lat_q.push_back(model_lat(o, b));
            exp_iss_q.push_back(cyc);
        end
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_issue: stall=%b required 1", stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        bit bad;
        n = 0;
        bad = 0;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (stall !== 1'b1 || busy !== 1'b1) bad = 1;
            n++;
            if (n > 100) begin
                errors++;
                $display("FAIL done_timeout: no done within %0d cycles, required done", n);
                return;
            end
        end
        checks++;
        if (bad || stall !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_busy_profile: stall/busy at done=%b/%b required 0/1 (bad_mid=%0d)", stall, busy, bad);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        drive_op(o, a, b, 1'b1, 1'b0);
        wait_done();
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({hi, lo} !== 64'h0 || {stall, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s: hi=%h lo=%h stall/busy/done=%b%b%b required all zero", name, hi, lo, stall, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_mult();
        run_op(2'b00, 32'hFFFFFFFD, 32'd7);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(2'b00, 32'h80000000, 32'h80000000);
        run_op(2'b00, 32'h00012345, 32'hFFFF0000);
    endtask

    task automatic test_div();
        run_op(2'b11, 32'd100, 32'd7);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2);
        run_op(2'b10, 32'd7, 32'hFFFFFFFE);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_op(2'b11, 32'hFFFFFFFF, 32'd3);
        run_op(2'b11, 32'd5, 32'd9);
    endtask

    task automatic test_div_zero();
        run_op(2'b10, 32'd5, 32'd0);
        run_op(2'b11, 32'hFFFFFF00, 32'd0);
        run_op(2'b10, 32'hFFFFFFF7, 32'd0);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mthi: hi=%h required 12345678", hi);
        end
        lo_we = 1'b1; wdata = 32'h0000A5A5;
        @(negedge clk);
        lo_we = 1'b0;
        checks++;
        if (lo !== 32'h0000A5A5) begin
            errors++;
            $display("FAIL mtlo: lo=%h required 0000a5a5", lo);
        end
        // MTLO and a second start inside CALC must both be ignored.
        drive_op(2'b01, 32'd1000, 32'd1000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd2;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        lo_we = 1'b0;
        checks++;
        if (lo !== 32'h0000A5A5 || hi !== 32'h12345678) begin
            errors++;
            $display("FAIL mtlo_in_calc: hi/lo=%h/%h required 12345678/0000a5a5", hi, lo);
        end
        wait_done();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_start_wins();
        drive_op(2'b01, 32'd6, 32'd7, 1'b1, 1'b1);
        wait_done();
    endtask

    task automatic test_reset_abort();
        drive_op(2'b01, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_abort");
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_early_term();
        run_op(2'b01, 32'd3, 32'd5);
        run_op(2'b01, 32'd12345, 32'd0);
        run_op(2'b00, 32'd5, 32'hFFFFFFFF);
        run_op(2'b00, 32'hFFFFFFF0, 32'h00000100);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom_range(1, 32'h7FFFFFFF);
            run_op(2'(i), a, b);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_start_wins();
        test_reset_abort();
        test_early_term();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: %0d ops without done, required 0", exp_res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
